// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the status-LED scheduler.
//   - led_state_e   : scheduler states (NORMAL / blink ON / blink OFF / inter-code GAP)
//   - ADDR_*        : CPU register addresses
//   - CTRL_*        : bit positions inside the control register
//   - DEF_*_LEVEL   : PWM levels loaded at reset
//   - max3()        : helper used to size the shared phase timer
package led_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_ON     = 2'd1,
      ST_OFF    = 2'd2,
      ST_GAP    = 2'd3
   } led_state_e;

   localparam logic [1:0] ADDR_IDLE   = 2'd0;
   localparam logic [1:0] ADDR_ACTIVE = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int CTRL_ACT_EN = 0;
   localparam int CTRL_ABORT  = 1;

   localparam logic [7:0] DEF_IDLE_LEVEL   = 8'd64;
   localparam logic [7:0] DEF_ACTIVE_LEVEL = 8'd255;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      else m = m;
      if (c > m) m = c;
      else m = m;
      return m;
   endfunction

endpackage

// File: rtl/led_pwm.sv
// led_pwm: 8-bit free-running PWM with a registered compare output.
//   clk, rst : clock, asynchronous active-high reset
//   level    : duty in 1/256 steps (0 = off, 255 = 255/256)
//   led      : registered drive, forced low asynchronously by rst
module led_pwm (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] level,
   output logic       led
);

   logic [7:0] pwm_cnt_r;
   logic       led_r;

   // Free-running counter and the registered compare against it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_r <= 8'd0;
         led_r     <= 1'b0;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + 8'd1;
         led_r     <= (level > pwm_cnt_r);
      end
   end

   assign led = led_r;

endmodule

// File: rtl/led_sched.sv
// led_sched: merges peripheral activity strobes and error blink codes onto a
// single PWM-dimmed status LED. Blink codes override activity indication.
//   clk, rst            : clock, asynchronous active-high reset
//   act[NSRC-1:0]       : single-cycle activity strobes (ORed)
//   err_valid/err_code  : blink-code request (count 0 = accepted and dropped)
//   err_ready           : high while idle; request accepted on valid && ready
//   wr_en/wr_addr/wr_data : CPU register write (idle level, active level, control)
//   busy                : blink code in progress
//   led                 : registered PWM LED drive
module led_sched
   import led_pkg::*;
#(
   parameter int         NSRC       = 4,
   parameter int         TICK_W     = 10,
   parameter int         HOLD_TICKS = 128,
   parameter int         ON_TICKS   = 200,
   parameter int         OFF_TICKS  = 200,
   parameter int         GAP_TICKS  = 800,
   parameter int         REPEAT     = 2,
   parameter logic [7:0] CODE_LEVEL = 8'd255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] act,
   input  logic            err_valid,
   input  logic [3:0]      err_code,
   output logic            err_ready,
   input  logic            wr_en,
   input  logic [1:0]      wr_addr,
   input  logic [7:0]      wr_data,
   output logic            busy,
   output logic            led
);

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int TMR_W  = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

   led_state_e        state_r, state_nx_s;
   logic [TICK_W-1:0] presc_r;
   logic [HOLD_W-1:0] hold_r;
   logic [TMR_W-1:0]  timer_r, timer_nx_s;
   logic [3:0]        bcnt_r, bcnt_nx_s, rcnt_r, rcnt_nx_s, code_r, code_nx_s;
   logic [7:0]        idle_level_r, active_level_r, level_s;
   logic              act_en_r, busy_r, err_ready_r;
   logic              tick_s, abort_s, start_s, phase_end_s;

   assign tick_s      = &presc_r;
   assign abort_s     = wr_en && (wr_addr == ADDR_CTRL) && wr_data[CTRL_ABORT];
   assign phase_end_s = tick_s && (timer_r == TMR_W'(1));

   // Prescaler; restarted when a code starts so the first ON phase is full length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc_r <= TICK_W'(0);
      else if (start_s) presc_r <= TICK_W'(0);
      else presc_r <= presc_r + TICK_W'(1);
   end

   // Activity hold counter: any strobe reloads, ticks count down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_r <= HOLD_W'(0);
      else if (|act) hold_r <= HOLD_W'(HOLD_TICKS);
      else if (tick_s && (hold_r != HOLD_W'(0))) hold_r <= hold_r - HOLD_W'(1);
      else hold_r <= hold_r;
   end

   // CPU register writes; the abort bit is a strobe and is never stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_level_r   <= DEF_IDLE_LEVEL;
         active_level_r <= DEF_ACTIVE_LEVEL;
         act_en_r       <= 1'b1;
      end else if (wr_en) begin
         case (wr_addr)
            ADDR_IDLE:   idle_level_r   <= wr_data;
            ADDR_ACTIVE: active_level_r <= wr_data;
            ADDR_CTRL:   act_en_r       <= wr_data[CTRL_ACT_EN];
            default:     act_en_r       <= act_en_r;
         endcase
      end else begin
         act_en_r <= act_en_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_NORMAL;
      else state_r <= state_nx_s;
   end

   // Phase timer, blink/repeat counters and latched code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_r <= TMR_W'(0);
         bcnt_r  <= 4'd0;
         rcnt_r  <= 4'd0;
         code_r  <= 4'd0;
      end else begin
         timer_r <= timer_nx_s;
         bcnt_r  <= bcnt_nx_s;
         rcnt_r  <= rcnt_nx_s;
         code_r  <= code_nx_s;
      end
   end

   // Next-state and counter update; abort overrides every phase transition.
   always_comb begin
      state_nx_s = state_r;
      bcnt_nx_s  = bcnt_r;
      rcnt_nx_s  = rcnt_r;
      code_nx_s  = code_r;
      start_s    = 1'b0;
      if (tick_s && (timer_r != TMR_W'(0))) timer_nx_s = timer_r - TMR_W'(1);
      else timer_nx_s = timer_r;

      if (abort_s) begin
         state_nx_s = ST_NORMAL;
         timer_nx_s = TMR_W'(0);
         bcnt_nx_s  = 4'd0;
         rcnt_nx_s  = 4'd0;
      end else begin
         case (state_r)
            ST_NORMAL: begin
               // A zero code completes the handshake but starts nothing.
               if (err_valid && (err_code != 4'd0)) begin
                  state_nx_s = ST_ON;
                  bcnt_nx_s  = err_code;
                  rcnt_nx_s  = 4'(REPEAT);
                  code_nx_s  = err_code;
                  timer_nx_s = TMR_W'(ON_TICKS);
                  start_s    = 1'b1;
               end else begin
                  state_nx_s = ST_NORMAL;
               end
            end
            ST_ON: begin
               if (phase_end_s) begin
                  state_nx_s = ST_OFF;
                  timer_nx_s = TMR_W'(OFF_TICKS);
               end else begin
                  state_nx_s = ST_ON;
               end
            end
            ST_OFF: begin
               if (phase_end_s && (bcnt_r > 4'd1)) begin
                  state_nx_s = ST_ON;
                  bcnt_nx_s  = bcnt_r - 4'd1;
                  timer_nx_s = TMR_W'(ON_TICKS);
               end else if (phase_end_s) begin
                  state_nx_s = ST_GAP;
                  timer_nx_s = TMR_W'(GAP_TICKS);
               end else begin
                  state_nx_s = ST_OFF;
               end
            end
            ST_GAP: begin
               if (phase_end_s && (rcnt_r > 4'd1)) begin
                  state_nx_s = ST_ON;
                  rcnt_nx_s  = rcnt_r - 4'd1;
                  bcnt_nx_s  = code_r;
                  timer_nx_s = TMR_W'(ON_TICKS);
               end else if (phase_end_s) begin
                  state_nx_s = ST_NORMAL;
                  timer_nx_s = TMR_W'(0);
               end else begin
                  state_nx_s = ST_GAP;
               end
            end
            default: begin
               state_nx_s = ST_NORMAL;
               timer_nx_s = TMR_W'(0);
            end
         endcase
      end
   end

   // Level mux: blink phases override the activity/idle level.
   always_comb begin
      level_s = idle_level_r;
      case (state_r)
         ST_ON:          level_s = CODE_LEVEL;
         ST_OFF, ST_GAP: level_s = 8'd0;
         ST_NORMAL: begin
            if (act_en_r && (hold_r != HOLD_W'(0))) level_s = active_level_r;
            else level_s = idle_level_r;
         end
         default:        level_s = idle_level_r;
      endcase
   end

   // Handshake flags registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         err_ready_r <= (state_nx_s == ST_NORMAL);
         busy_r      <= (state_nx_s != ST_NORMAL);
      end
   end

   assign err_ready = err_ready_r;
   assign busy      = busy_r;

   led_pwm u_pwm (
      .clk   (clk),
      .rst   (rst),
      .level (level_s),
      .led   (led)
   );

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: self-checking bench for led_sched using small timing parameters.
// A cycle-accurate reference model describes a blink code as a queue of
// (level, duration) segments and activity as a tick-counted hold window.
module tb_led_sched;

   localparam int TW    = 4;
   localparam int HOLD  = 4;
   localparam int ON_T  = 2;
   localparam int OFF_T = 2;
   localparam int GAP_T = 4;
   localparam int REP   = 2;
   localparam int TCLK  = 1 << TW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] act = 4'd0;
   logic       err_valid = 1'b0;
   logic [3:0] err_code = 4'd0;
   logic       err_ready;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic       busy;
   logic       led;

   int n_chk = 0;
   int n_fail = 0;

   led_sched #(
      .NSRC(4), .TICK_W(TW), .HOLD_TICKS(HOLD), .ON_TICKS(ON_T),
      .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T), .REPEAT(REP), .CODE_LEVEL(8'd255)
   ) dut (
      .clk(clk), .rst(rst), .act(act), .err_valid(err_valid), .err_code(err_code),
      .err_ready(err_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .led(led)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {int lvl; int rem;} seg_t;
   seg_t q[$];
   int   m_presc, m_hold, m_cnt, m_idle, m_active;
   bit   m_act_en, m_busy, m_accepted, exp_led;

   function automatic void model_reset();
      q.delete();
      m_presc = 0; m_hold = 0; m_cnt = 0;
      m_idle = 64; m_active = 255; m_act_en = 1'b1;
      m_busy = 1'b0; m_accepted = 1'b0; exp_led = 1'b0;
   endfunction

   function automatic int m_level();
      if (q.size() != 0) return q[0].lvl;
      else if (m_act_en && m_hold != 0) return m_active;
      else return m_idle;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   function automatic void model_edge();
      bit tick, abort, start, was_busy;
      exp_led  = (m_level() > m_cnt);
      m_cnt    = (m_cnt + 1) % 256;
      tick     = (m_presc == TCLK - 1);
      abort    = wr_en && (wr_addr == 2'd2) && wr_data[1];
      was_busy = (q.size() != 0);
      start    = 1'b0;
      m_accepted = !was_busy && err_valid;
      if (abort) q.delete();
      else if (was_busy) begin
         q[0].rem = q[0].rem - 1;
         if (q[0].rem == 0) void'(q.pop_front());
      end else if (err_valid && err_code != 4'd0) begin
         start = 1'b1;
         for (int r = 0; r < REP; r++) begin
            for (int b = 0; b < int'(err_code); b++) begin
               q.push_back('{255, ON_T * TCLK});
               q.push_back('{0, OFF_T * TCLK});
            end
            q.push_back('{0, GAP_T * TCLK});
         end
      end
      if (act != 4'd0) m_hold = HOLD;
      else if (tick && m_hold > 0) m_hold = m_hold - 1;
      m_presc = start ? 0 : (m_presc + 1) % TCLK;
      if (wr_en) begin
         if (wr_addr == 2'd0) m_idle = int'(wr_data);
         else if (wr_addr == 2'd1) m_active = int'(wr_data);
         else if (wr_addr == 2'd2) m_act_en = wr_data[0];
      end
      m_busy = (q.size() != 0);
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("led", 32'(led), 32'(exp_led));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("err_ready", 32'(err_ready), 32'(!m_busy));
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic measure(output int s);
      s = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         s += int'(led);
      end
   endtask

   typedef struct {logic [1:0] addr; logic [7:0] data; int exp_duty;} vec_t;
   vec_t tbl[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, cnt;
      tbl[0] = '{2'd0, 8'd0,   0};
      tbl[1] = '{2'd0, 8'd255, 255};
      tbl[2] = '{2'd0, 8'd1,   1};
      tbl[3] = '{2'd1, 8'd200, 1};
      tbl[4] = '{2'd0, 8'd128, 128};
      tbl[5] = '{2'd0, 8'd64,  64};

      // Reset state
      #22 rst = 1'b0;
      model_reset();
      #1;
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(err_ready), 32'd1);

      // Default idle duty
      measure(s);
      chk("duty_default", s, 64);

      // Table-driven level writes, each measured over one PWM period
      for (int i = 0; i < 6; i++) begin
         wr(tbl[i].addr, tbl[i].data);
         measure(s);
         chk("duty_tbl", s, tbl[i].exp_duty);
      end

      // Single activity pulse on source 2, then let the hold expire
      act = 4'b0100;
      step();
      act = 4'd0;
      for (int i = 0; i < 100; i++) step();

      // Code 3: busy for (3*64 + 64) * 2 clocks
      err_valid = 1'b1; err_code = 4'd3;
      step();
      err_valid = 1'b0;
      cnt = busy ? 1 : 0;
      for (int i = 0; i < 2000 && busy; i++) begin
         step();
         if (busy) cnt++;
      end
      chk("busy_len", cnt, 512);

      // Zero code: handshake only
      err_valid = 1'b1; err_code = 4'd0;
      step();
      err_valid = 1'b0;
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_ready", 32'(err_ready), 32'd1);

      // Request held while busy is stalled, then taken on the first idle cycle
      err_valid = 1'b1; err_code = 4'd1;
      step();
      err_code = 4'd2;
      for (int i = 0; i < 1000 && busy; i++) step();
      chk("stall_idle", 32'(busy), 32'd0);
      step();
      err_valid = 1'b0;
      chk("stall_accept", 32'(busy), 32'd1);

      // Abort in the middle of the first ON phase
      for (int i = 0; i < 10; i++) step();
      wr(2'd2, 8'h03);
      chk("abort_busy", 32'(busy), 32'd0);
      measure(s);
      chk("abort_duty", s, 64);

      // Activity disabled: pulses must not lift the level
      wr(2'd2, 8'h00);
      s = 0;
      for (int i = 0; i < 256; i++) begin
         act = (i % 40 == 0) ? 4'b1111 : 4'd0;
         step();
         s += int'(led);
      end
      act = 4'd0;
      chk("act_dis_duty", s, 64);
      wr(2'd2, 8'h01);

      // Asynchronous reset in the middle of an OFF phase
      wr(2'd0, 8'd10);
      err_valid = 1'b1; err_code = 4'd2;
      step();
      err_valid = 1'b0;
      for (int i = 0; i < 40; i++) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_led", 32'(led), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(err_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      measure(s);
      chk("arst_duty", s, 64);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         act = 4'd0;
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 31) == 0) act[b] = 1'b1;
         wr_en   = ($urandom_range(0, 63) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 8'($urandom);
         if (wr_addr == 2'd2) begin
            wr_data[1] = ($urandom_range(0, 3) == 0);
            wr_data[0] = ($urandom_range(0, 3) != 0);
         end
         if (!err_valid && $urandom_range(0, 149) == 0) begin
            err_valid = 1'b1;
            err_code  = 4'($urandom_range(0, 3));
         end
         step();
         if (m_accepted) err_valid = 1'b0;
      end
      act = 4'd0; wr_en = 1'b0; err_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/led_sched.md
Name: led_sched

Overview:
- Status-LED controller: merges activity pulses from NSRC requesters (SD, SPI, UART, audio) and sequences error blink codes onto one PWM-dimmed LED pin.
- Blink codes take priority over activity indication.
- Levels and control come from a small CPU-side register write port.
- Sits between the peripheral activity strobes and the top-level LED pin.

Parameters:
- NSRC, 4, number of activity sources
- TICK_W, 10, prescaler width; one tick every 2^TICK_W clocks
- HOLD_TICKS, 128, ticks the active level is held after the last activity pulse
- ON_TICKS, 200, blink ON phase length in ticks
- OFF_TICKS, 200, blink OFF phase length in ticks
- GAP_TICKS, 800, pause after each complete code, in ticks
- REPEAT, 2, number of times each accepted code is shown (1..15)
- CODE_LEVEL, 8'd255, PWM level during ON phase

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- act  in  NSRC  per-source single-cycle activity strobes, ORed
- err_valid  in  1  blink-code request valid
- err_code  in  4  blink count (0 = no-op)
- err_ready  out  1  code accepted when err_valid && err_ready
- wr_en  in  1  register write strobe
- wr_addr  in  2  0 = idle level, 1 = active level, 2 = control
- wr_data  in  8  write data; control bit0 = act_en, bit1 = abort (self-clearing)
- busy  out  1  blink code in progress
- led  out  1  registered PWM LED drive

Behaviour:
- Reset values: state NORMAL, led 0, busy 0, err_ready 1, idle_level 64, active_level 255, act_en 1, all counters 0.
- Prescaler: free-running TICK_W-bit counter. tick is asserted when it equals all-ones. Accepting a code clears the prescaler, so the first phase is exactly ON_TICKS*2^TICK_W clocks.
- Hold counter, HOLD_TICKS width via clog2:
  - any act bit set -> load HOLD_TICKS;
  - else on tick, if nonzero -> decrement;
  - load wins over decrement in the same cycle;
  - reloads in all states.
- States: NORMAL, ON, OFF, GAP.
  - Phase timer is loaded on entry to a state and decremented on tick.
  - A phase ends on a tick with timer == 1.
  - Blink counter bcnt and repeat counter rcnt are 4-bit.
- Transitions:
  - NORMAL: err_valid && err_code != 0 -> ON; bcnt = err_code, rcnt = REPEAT, timer = ON_TICKS.
  - NORMAL: err_code == 0 is accepted (handshake completes) and dropped; state is unchanged.
  - ON end -> OFF; timer = OFF_TICKS.
  - OFF end: bcnt > 1 -> bcnt--, ON. bcnt == 1 -> GAP; timer = GAP_TICKS.
  - GAP end: rcnt > 1 -> rcnt--, bcnt reloaded from latched code, ON. rcnt == 1 -> NORMAL.
- Abort (write control bit1 = 1): next cycle the state is NORMAL and timer, bcnt and rcnt are 0. Abort takes priority over any phase transition in the same cycle.
- err_ready = (state == NORMAL). busy = !err_ready. The code is latched on accept. Requests during busy are stalled, never dropped.
- Level mux:
  - ON -> CODE_LEVEL;
  - OFF or GAP -> 0;
  - NORMAL -> active_level if (act_en && hold != 0), else idle_level.
- PWM: 8-bit free-running counter. led <= (level > pwm_cnt). Level 0 is fully off; level 255 gives 255/256 duty.
- Latency: act at cycle t -> hold nonzero at t+1 -> led reflects the new level from t+2.
- A register write takes effect on the level the cycle after wr_en.
- Reset asserted mid-sequence returns everything to the reset values immediately; the LED goes off asynchronously.

Decomposition:
- Package led_pkg holds:
  - state enum;
  - register address constants (ADDR_IDLE, ADDR_ACTIVE, ADDR_CTRL);
  - control bit indices;
  - default level constants (64, 255).
- One sub-module, led_pwm: 8-bit counter plus registered compare, with inputs clk, rst, level[7:0] and output led.

Test Plan (TICK_W=4, HOLD_TICKS=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=4, REPEAT=2):
- After reset, no stimulus -> led duty 64/256 measured over 256 clocks; busy 0, err_ready 1.
- act[2] single pulse -> duty 255/256 from cycle +2 until hold expires (49..64 clocks later), then back to 64/256.
- err_code=3 accepted -> ON/OFF pattern 32/32 clocks ×3, GAP 64 clocks, repeated twice; busy high for 512 clocks; then NORMAL with err_ready 1.
- err_code=0 with valid -> handshake completes in 1 cycle; state stays NORMAL, busy stays 0.
- Second err_valid held during busy -> err_ready 0 throughout; accepted on the first NORMAL cycle.
- Abort written mid-ON -> busy 0 next cycle, led returns to idle level.
- act_en=0 plus activity pulses -> level stays at idle_level.
- Async rst pulse mid-OFF -> led 0, state NORMAL, default levels restored.
